// File: rtl/ras_ckpt.sv
// ras_ckpt: return address stack with tagged checkpoints that repair head, count and a clobbered TOS on mispredict
module ras_ckpt #(
  parameter int PC_BITS    = 32,
  parameter int SIZE       = 16,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [PC_BITS-1:0]            new_entry,
  output logic [PC_BITS-1:0]            pc_out,
  output logic                          is_empty,
  output logic [$clog2(SIZE):0]         count,
  input  logic                          ckpt_alloc,
  output logic                          ckpt_ready,
  output logic [$clog2(CKPT_DEPTH)-1:0] ckpt_id,
  input  logic                          resolve,
  input  logic                          mispredict,
  input  logic [$clog2(CKPT_DEPTH)-1:0] mispredict_id,
  input  logic                          flush_all
);
  localparam int HW = $clog2(SIZE);
  localparam int IW = $clog2(CKPT_DEPTH);
  localparam int EW = PC_BITS - 1;
  localparam logic [HW-1:0] H1    = 1;
  localparam logic [HW:0]   C1    = 1;
  localparam logic [HW:0]   FULL  = (HW+1)'(SIZE);
  localparam logic [IW:0]   CFULL = (IW+1)'(CKPT_DEPTH);
  logic [EW-1:0] stk [SIZE];
  logic [HW-1:0] ck_head [CKPT_DEPTH];
  logic [HW:0]   ck_cnt [CKPT_DEPTH];
  logic [EW-1:0] ck_tos [CKPT_DEPTH];
  logic [HW-1:0] head, r_head;
  logic [HW:0]   cnt, r_cnt;
  logic [IW:0]   wr, rd, held;
  logic [IW-1:0] off;
  logic [EW-1:0] tos;
  logic          mp_ok, alloc_ok, do_res, do_push, do_pop, unused_lsb;
  assign unused_lsb = new_entry[0];
  assign tos        = stk[head - H1];
  assign held       = wr - rd;
  // age of the mispredicted branch relative to the oldest held checkpoint
  assign off        = mispredict_id - rd[IW-1:0];
  assign mp_ok      = mispredict & ~flush_all & ({1'b0, off} < held);
  assign alloc_ok   = ckpt_alloc & ckpt_ready & ~mispredict & ~flush_all;
  assign do_res     = resolve & ~flush_all & (held != '0);
  assign do_push    = push & ~mp_ok;
  assign do_pop     = pop & ~mp_ok & (cnt != '0);
  assign r_head     = ck_head[mispredict_id];
  assign r_cnt      = ck_cnt[mispredict_id];
  assign pc_out     = (cnt != '0) ? {tos, 1'b0} : '0;
  assign is_empty   = cnt == '0;
  assign count      = cnt;
  assign ckpt_ready = held != CFULL;
  assign ckpt_id    = wr[IW-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      cnt  <= '0;
      wr   <= '0;
      rd   <= '0;
    end else begin
      if (mp_ok) begin
        head <= r_head;
        cnt  <= r_cnt;
      end else if (do_push && !do_pop) begin
        head <= head + H1;
        cnt  <= (cnt == FULL) ? cnt : cnt + C1;
      end else if (do_pop && !push) begin
        head <= head - H1;
        cnt  <= cnt - C1;
      end
      rd <= rd + {{IW{1'b0}}, do_res};
      // resolving the very checkpoint being restored leaves the FIFO empty
      wr <= flush_all ? rd :
            mp_ok     ? rd + {1'b0, off} + {{IW{1'b0}}, do_res && off == '0} :
                        wr + {{IW{1'b0}}, alloc_ok};
    end
  end
  always_ff @(posedge clk) begin
    if (mp_ok && r_cnt != '0) stk[r_head - H1] <= ck_tos[mispredict_id];
    else if (do_push) stk[do_pop ? head - H1 : head] <= new_entry[PC_BITS-1:1];
    if (alloc_ok) begin
      ck_head[wr[IW-1:0]] <= head;
      ck_cnt[wr[IW-1:0]]  <= cnt;
      ck_tos[wr[IW-1:0]]  <= tos;
    end
  end
endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed and random stimulus against a queue-based model of the return address stack
module tb_ras_ckpt;
  localparam int SZ = 16;
  localparam int CD = 4;
  logic        clk = 0, rst_n = 0;
  logic        push = 0, pop = 0, ckpt_alloc = 0, resolve = 0, mispredict = 0, flush_all = 0;
  logic [31:0] new_entry = 0, pc_out;
  logic        is_empty, ckpt_ready;
  logic [4:0]  count;
  logic [1:0]  ckpt_id, mispredict_id = 0;
  int n_chk = 0, n_err = 0;
  typedef struct {int id; int h; int c; int t;} ck_t;
  int  m_mem [SZ];
  int  m_head = 0, m_cnt = 0, nid = 0;
  ck_t ckq [$];

  ras_ckpt dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .new_entry(new_entry),
    .pc_out(pc_out), .is_empty(is_empty), .count(count),
    .ckpt_alloc(ckpt_alloc), .ckpt_ready(ckpt_ready), .ckpt_id(ckpt_id),
    .resolve(resolve), .mispredict(mispredict), .mispredict_id(mispredict_id),
    .flush_all(flush_all)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int below(input int h);
    return (h + SZ - 1) % SZ;
  endfunction

  task automatic model(input logic pu, po, input logic [31:0] ne, input logic al, rs, mp,
                       input int mid, input logic fl);
    int held = ckq.size();
    int k = -1;
    bit a_ok = al && held < CD && !mp && !fl;
    ck_t snap = '{nid, m_head, m_cnt, m_mem[below(m_head)]};
    if (mp && !fl)
      for (int i = 0; i < held; i++) if (ckq[i].id == mid) k = i;
    if (k >= 0) begin
      m_head = ckq[k].h;
      m_cnt  = ckq[k].c;
      if (m_cnt > 0) m_mem[below(m_head)] = ckq[k].t;
    end else if (pu && po && m_cnt > 0) m_mem[below(m_head)] = int'(ne >> 1);
    else if (pu) begin
      m_mem[m_head] = int'(ne >> 1);
      m_head = (m_head + 1) % SZ;
      if (m_cnt < SZ) m_cnt++;
    end else if (po && m_cnt > 0) begin
      m_head = below(m_head);
      m_cnt--;
    end
    if (fl) begin
      if (held > 0) nid = ckq[0].id;
      ckq.delete();
    end else begin
      if (k >= 0) begin
        nid = mid;
        while (ckq.size() > k) void'(ckq.pop_back());
      end
      if (rs && held > 0) begin
        if (k == 0) nid = (mid + 1) % CD;
        else void'(ckq.pop_front());
      end
      if (a_ok) begin
        ckq.push_back(snap);
        nid = (nid + 1) % CD;
      end
    end
  endtask

  task automatic compare(input string tag);
    logic [31:0] e_pc = (m_cnt > 0) ? 32'(m_mem[below(m_head)]) << 1 : 32'h0;
    chk({tag, "_pc"}, pc_out, e_pc);
    chk({tag, "_count"}, count, m_cnt);
    chk({tag, "_empty"}, is_empty, m_cnt == 0);
    chk({tag, "_ready"}, ckpt_ready, ckq.size() < CD);
    chk({tag, "_id"}, ckpt_id, nid);
  endtask

  task automatic step(input string tag, input logic pu, po, input logic [31:0] ne,
                      input logic al = 0, rs = 0, mp = 0, input int mid = 0, input logic fl = 0);
    push = pu; pop = po; new_entry = ne; ckpt_alloc = al; resolve = rs;
    mispredict = mp; mispredict_id = 2'(mid); flush_all = fl;
    @(posedge clk);
    model(pu, po, ne, al, rs, mp, mid, fl);
    #1;
    compare(tag);
  endtask

  task automatic idle_inputs;
    push = 0; pop = 0; ckpt_alloc = 0; resolve = 0; mispredict = 0; flush_all = 0;
  endtask

  initial begin
    #12;
    chk("rst_pc", pc_out, 0);
    chk("rst_empty", is_empty, 1);
    chk("rst_count", count, 0);
    chk("rst_ready", ckpt_ready, 1);
    chk("rst_id", ckpt_id, 0);
    rst_n = 1;
    // stack basics and pop-when-empty
    step("t1", 1, 0, 32'h100); step("t1", 1, 0, 32'h200); step("t1", 1, 0, 32'h300);
    chk("t1_cnt3", count, 3);
    chk("t1_pc300", pc_out, 32'h300);
    step("t1", 0, 1, 0);
    chk("t1_pc200", pc_out, 32'h200);
    step("t1", 0, 1, 0); step("t1", 0, 1, 0);
    chk("t1_empty", is_empty, 1);
    step("t1x", 0, 1, 0);
    chk("t1x_count", count, 0);
    // overflow overwrites the oldest entries
    for (int i = 0; i < SZ + 2; i++) step("t2push", 1, 0, 32'hA0 + 32'(i) * 2);
    chk("t2_full", count, 16);
    for (int i = 0; i < SZ; i++) begin
      chk("t2_pop_pc", pc_out, 32'hA0 + 32'(SZ + 1 - i) * 2);
      step("t2pop", 0, 1, 0);
    end
    chk("t2_empty", is_empty, 1);
    // TOS repair on mispredict
    step("t3", 1, 0, 32'h40); step("t3", 1, 0, 32'h80);
    chk("t3_id0", ckpt_id, 0);
    step("t3", 0, 0, 0, 1);
    step("t3", 0, 1, 0);
    step("t3", 1, 0, 32'h999);
    step("t3", 0, 0, 0, 0, 0, 1, 0);
    chk("t3_count", count, 2);
    chk("t3_pc", pc_out, 32'h80);
    chk("t3_ready", ckpt_ready, 1);
    // fill the checkpoint FIFO, partial restore, drain
    for (int i = 0; i < CD; i++) step("t4alloc", 0, 0, 0, 1);
    chk("t4_notready", ckpt_ready, 0);
    step("t4extra", 0, 0, 0, 1);
    step("t4mp", 0, 0, 0, 0, 0, 1, 2);
    chk("t4_nextid", ckpt_id, 2);
    step("t4res", 0, 0, 0, 0, 1); step("t4res", 0, 0, 0, 0, 1);
    chk("t4_ready", ckpt_ready, 1);
    // push and pop together
    step("t5", 1, 0, 32'h500);
    step("t5pp", 1, 1, 32'h700);
    chk("t5_pc", pc_out, 32'h700);
    while (count != 0 && n_chk < 1000) step("t5drain", 0, 1, 0);
    step("t5ppe", 1, 1, 32'h700);
    chk("t5e_count", count, 1);
    chk("t5e_pc", pc_out, 32'h700);
    // flush keeps the stack op, drops checkpoints
    step("t6", 0, 0, 0, 1); step("t6", 0, 0, 0, 1);
    step("t6fl", 1, 0, 32'h600, 0, 0, 0, 0, 1);
    chk("t6_pc", pc_out, 32'h600);
    step("t6mp", 0, 0, 0, 0, 0, 1, 0);
    chk("t6_mp_ignored", pc_out, 32'h600);
    idle_inputs();
    // random traffic
    for (int i = 0; i < 3000; i++)
      step("rnd", $urandom_range(99) < 45, $urandom_range(99) < 35, $urandom,
           $urandom_range(99) < 40, $urandom_range(99) < 20, $urandom_range(99) < 12,
           int'($urandom_range(CD - 1)), $urandom_range(99) < 3);
    // asynchronous reset mid-cycle
    step("pre_rst", 1, 0, 32'h1234, 1);
    idle_inputs();
    #2 rst_n = 0;
    #1;
    m_head = 0; m_cnt = 0; nid = 0; ckq.delete();
    chk("arst_pc", pc_out, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", is_empty, 1);
    chk("arst_ready", ckpt_ready, 1);
    chk("arst_id", ckpt_id, 0);
    #3 rst_n = 1;
    for (int i = 0; i < 200; i++)
      step("post", $urandom_range(99) < 50, $urandom_range(99) < 30, $urandom,
           $urandom_range(99) < 40, $urandom_range(99) < 20, $urandom_range(99) < 10,
           int'($urandom_range(CD - 1)), $urandom_range(99) < 3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
